// File: rtl/mem_pkg.sv
// Shared types and line-geometry helpers for the memory request arbiter.
package mem_pkg;

  localparam int unsigned ADDR_BITS  = 32;
  localparam int unsigned LINE_BYTES = 16;
  localparam int unsigned LINE_BITS  = 128;
  localparam int unsigned LAT_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } arb_state_t;

  typedef enum logic {
    SRC_DEMAND,
    SRC_PREFETCH
  } req_src_t;

  function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] addr);
    return addr & ~ADDR_BITS'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the memory access window; saturates at zero.
module mem_lat_counter
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH = LAT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_req_arbiter.sv
// Demand/prefetch arbiter in front of a fixed-latency line memory.
// Demand wins ties; a demand read hitting the in-flight prefetch line is merged.
module mem_req_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_valid,
  output logic                 d_ready,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic                 d_we,
  input  logic [LINE_BITS-1:0] d_wdata,
  input  logic                 p_valid,
  output logic                 p_ready,
  input  logic [ADDR_BITS-1:0] p_addr,
  output logic                 d_resp_valid,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 p_resp_valid,
  output logic [LINE_BITS-1:0] p_rdata,
  output logic [ADDR_BITS-1:0] p_resp_addr,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [LINE_BITS-1:0] mem_din,
  output logic                 mem_we,
  input  logic [LINE_BITS-1:0] mem_dout
);

  localparam logic [LAT_CNT_W-1:0] LOAD_VAL = LAT_CNT_W'(LATENCY - 1);

  arb_state_t           r_state;
  req_src_t             r_src;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_we;
  logic [LINE_BITS-1:0] r_wdata;
  logic                 r_merged;
  logic                 r_armed;
  logic                 r_d_resp_valid;
  logic [LINE_BITS-1:0] r_d_rdata;
  logic                 r_p_resp_valid;
  logic [LINE_BITS-1:0] r_p_rdata;
  logic [ADDR_BITS-1:0] r_p_resp_addr;

  logic w_idle;
  logic w_busy;
  logic w_d_acc;
  logic w_p_acc;
  logic w_merge_acc;
  logic w_cnt_zero;
  logic w_last;
  logic w_d_served;

  // r_armed keeps both readies low until the first clock edge after reset.
  assign w_idle      = r_armed && (r_state == ST_IDLE);
  assign w_busy      = (r_state == ST_BUSY);
  assign w_d_acc     = w_idle && d_valid;
  assign w_p_acc     = w_idle && !d_valid && p_valid;
  assign w_merge_acc = w_busy && (r_src == SRC_PREFETCH) && !r_merged && d_valid && !d_we &&
                       (line_align(d_addr) == r_addr);
  assign w_last      = w_busy && w_cnt_zero;
  assign w_d_served  = (r_src == SRC_DEMAND) || r_merged || w_merge_acc;

  assign d_ready = w_idle || w_merge_acc;
  assign p_ready = w_idle && !d_valid;

  assign mem_addr = w_busy ? r_addr  : '0;
  assign mem_din  = w_busy ? r_wdata : '0;
  assign mem_we   = w_last && r_we;

  assign d_resp_valid = r_d_resp_valid;
  assign d_rdata      = r_d_rdata;
  assign p_resp_valid = r_p_resp_valid;
  assign p_rdata      = r_p_rdata;
  assign p_resp_addr  = r_p_resp_addr;

  mem_lat_counter #(
    .WIDTH (LAT_CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_d_acc || w_p_acc),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_busy),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_src          <= SRC_DEMAND;
      r_addr         <= '0;
      r_we           <= 1'b0;
      r_wdata        <= '0;
      r_merged       <= 1'b0;
      r_armed        <= 1'b0;
      r_d_resp_valid <= 1'b0;
      r_d_rdata      <= '0;
      r_p_resp_valid <= 1'b0;
      r_p_rdata      <= '0;
      r_p_resp_addr  <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_d_acc) begin
            r_state  <= ST_BUSY;
            r_src    <= SRC_DEMAND;
            r_addr   <= line_align(d_addr);
            r_we     <= d_we;
            r_wdata  <= d_wdata;
            r_merged <= 1'b0;
          end else if (w_p_acc) begin
            r_state  <= ST_BUSY;
            r_src    <= SRC_PREFETCH;
            r_addr   <= line_align(p_addr);
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_merged <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_merge_acc) begin
            r_merged <= 1'b1;
          end
          // A merge accepted on the final cycle still joins this response.
          if (w_cnt_zero) begin
            r_state        <= ST_RESP;
            r_d_resp_valid <= w_d_served;
            r_d_rdata      <= (w_d_served && !r_we) ? mem_dout : '0;
            r_p_resp_valid <= (r_src == SRC_PREFETCH);
            r_p_rdata      <= (r_src == SRC_PREFETCH) ? mem_dout : '0;
            r_p_resp_addr  <= (r_src == SRC_PREFETCH) ? r_addr : '0;
          end
        end
        ST_RESP: begin
          r_state        <= ST_IDLE;
          r_merged       <= 1'b0;
          r_d_resp_valid <= 1'b0;
          r_d_rdata      <= '0;
          r_p_resp_valid <= 1'b0;
          r_p_rdata      <= '0;
          r_p_resp_addr  <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed scenarios and random traffic.
module tb_mem_req_arbiter;

  localparam int unsigned L = 4;
  localparam logic [127:0] LINE1 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] LINE3 = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] LINE4 = 128'h44444444_12345678_44444444_9ABCDEF0;
  localparam logic [127:0] DEAD  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         d_valid = 1'b0;
  logic         d_ready;
  logic [31:0]  d_addr = '0;
  logic         d_we = 1'b0;
  logic [127:0] d_wdata = '0;
  logic         p_valid = 1'b0;
  logic         p_ready;
  logic [31:0]  p_addr = '0;
  logic         d_resp_valid;
  logic [127:0] d_rdata;
  logic         p_resp_valid;
  logic [127:0] p_rdata;
  logic [31:0]  p_resp_addr;
  logic [31:0]  mem_addr;
  logic [127:0] mem_din;
  logic         mem_we;
  logic [127:0] mem_dout;

  int checks = 0;
  int errors = 0;
  int we_pulses = 0;

  logic [127:0] mem   [0:63];
  logic [127:0] m_mem [0:63];

  // Reference model: transaction in flight, e = edges since the accepting edge.
  bit           m_active = 1'b0;
  bit           m_armed  = 1'b0;
  int           m_e      = 0;
  bit           m_src_p  = 1'b0;
  logic [31:0]  m_addr   = '0;
  bit           m_we     = 1'b0;
  logic [127:0] m_wdata  = '0;
  bit           m_merged = 1'b0;
  logic [127:0] m_data   = '0;

  mem_req_arbiter #(.LATENCY(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_addr       (d_addr),
    .d_we         (d_we),
    .d_wdata      (d_wdata),
    .p_valid      (p_valid),
    .p_ready      (p_ready),
    .p_addr       (p_addr),
    .d_resp_valid (d_resp_valid),
    .d_rdata      (d_rdata),
    .p_resp_valid (p_resp_valid),
    .p_rdata      (p_rdata),
    .p_resp_addr  (p_resp_addr),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .mem_dout     (mem_dout)
  );

  initial forever #5 clk = ~clk;

  assign mem_dout = (mem_addr < 32'h400) ? mem[mem_addr[9:4]] : 128'h0;

  function automatic logic [127:0] init_line(input int unsigned i);
    case (i)
      1:       return LINE1;
      3:       return LINE3;
      4:       return LINE4;
      default: return {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'hA5A50000, 32'(i) * 32'h01000193, ~32'(i)};
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0)
      return 32'h400 + 32'($urandom_range(0, 63) << 4) + 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 7) << 4) | 32'($urandom_range(0, 15));
  endfunction

  function automatic bit exp_d_ready();
    if (!m_armed) return 1'b0;
    if (!m_active) return 1'b1;
    return (m_e < L) && m_src_p && !m_merged && d_valid && !d_we && ({d_addr[31:4], 4'h0} == m_addr);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Line memory environment: combinational read, write on the clock edge.
  initial begin
    for (int unsigned i = 0; i < 64; i++) mem[i] = init_line(i);
    forever begin
      @(posedge clk);
      if (mem_we === 1'b1) begin
        we_pulses++;
        if (mem_addr < 32'h400) mem[mem_addr[9:4]] = mem_din;
      end
    end
  end

  // Model + per-cycle compare; inputs are stable from posedge+1 to the next posedge.
  initial begin
    bit busy, resp, dv, dr;
    for (int unsigned i = 0; i < 64; i++) m_mem[i] = init_line(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 1'b0; m_armed = 1'b0; m_merged = 1'b0; m_e = 0;
      end
      busy = m_active && (m_e < L);
      resp = m_active && (m_e == L);
      dv   = resp && (!m_src_p || m_merged);
      chk("d_ready", d_ready, exp_d_ready());
      chk("p_ready", p_ready, m_armed && !m_active && !d_valid);
      chk("mem_addr", mem_addr, busy ? m_addr : 32'h0);
      if (!busy || m_we) chk("mem_din", mem_din, busy ? m_wdata : 128'h0);
      chk("mem_we", mem_we, busy && (m_e == L - 1) && m_we);
      chk("d_resp_valid", d_resp_valid, dv);
      chk("d_rdata", d_rdata, (dv && !m_we) ? m_data : 128'h0);
      chk("p_resp_valid", p_resp_valid, resp && m_src_p);
      chk("p_rdata", p_rdata, (resp && m_src_p) ? m_data : 128'h0);
      chk("p_resp_addr", p_resp_addr, (resp && m_src_p) ? m_addr : 32'h0);
      if (!rst) begin
        dr = exp_d_ready();
        if (!m_active) begin
          if (m_armed && d_valid) begin
            m_active = 1'b1; m_e = 0; m_src_p = 1'b0; m_merged = 1'b0;
            m_addr = {d_addr[31:4], 4'h0}; m_we = d_we; m_wdata = d_wdata;
          end else if (m_armed && p_valid) begin
            m_active = 1'b1; m_e = 0; m_src_p = 1'b1; m_merged = 1'b0;
            m_addr = {p_addr[31:4], 4'h0}; m_we = 1'b0; m_wdata = '0;
          end
        end else begin
          if (d_valid && dr) m_merged = 1'b1;
          if (m_e == L - 1) begin
            if (m_we) begin
              if (m_addr < 32'h400) m_mem[m_addr[9:4]] = m_wdata;
            end else begin
              m_data = (m_addr < 32'h400) ? m_mem[m_addr[9:4]] : 128'h0;
            end
          end
          m_e++;
          if (m_e == L + 1) m_active = 1'b0;
        end
        m_armed = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one demand request and check its timing and response data.
  task automatic demand_check(input logic [31:0] a, input logic we, input logic [127:0] wd,
                              input logic [127:0] exp);
    bit got = 1'b0;
    tick();
    d_valid = 1'b1; d_addr = a; d_we = we; d_wdata = wd;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = d_ready;
    end
    if (!got) begin
      chk("d_accept_timeout", 1'b0, 1'b1);
      tick();
      d_valid = 1'b0;
      return;
    end
    tick();
    d_valid = 1'b0;
    for (int i = 0; i <= int'(L); i++) begin
      @(negedge clk);
      chk("dir_mem_we", mem_we, we && (i == int'(L) - 1));
      chk("dir_d_resp_valid", d_resp_valid, i == int'(L));
    end
    chk("dir_d_rdata", d_rdata, exp);
  endtask

  initial begin
    bit df, pf;
    int rc, we_before;
    #1;
    chk("rst_d_ready", d_ready, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("release_d_ready_low", d_ready, 1'b0);
    @(negedge clk);
    chk("release_d_ready_high", d_ready, 1'b1);

    // Aligned read of a known line.
    demand_check(32'h0000_0010, 1'b0, '0, LINE1);

    // Simultaneous requests: demand first, prefetch in the IDLE after demand RESP.
    tick();
    d_valid = 1'b1; d_addr = 32'h54; d_we = 1'b0; p_valid = 1'b1; p_addr = 32'h60;
    @(negedge clk);
    chk("tie_d_ready", d_ready, 1'b1);
    chk("tie_p_ready", p_ready, 1'b0);
    tick();
    d_valid = 1'b0;
    for (int i = 0; i <= int'(L) + 1; i++) begin
      @(negedge clk);
      chk("tie_p_wait", p_ready, i == int'(L) + 1);
    end
    tick();
    p_valid = 1'b0;
    for (int i = 0; i <= int'(L); i++) begin
      @(negedge clk);
      chk("tie_p_resp", p_resp_valid, i == int'(L));
    end
    chk("tie_p_resp_addr", p_resp_addr, 32'h60);

    // Demand read merged into an in-flight prefetch of the same line.
    tick();
    p_valid = 1'b1; p_addr = 32'h40;
    @(negedge clk);
    chk("merge_p_ready", p_ready, 1'b1);
    tick();
    p_valid = 1'b0;
    tick();
    d_valid = 1'b1; d_addr = 32'h4C; d_we = 1'b0;
    @(negedge clk);
    chk("merge_d_ready", d_ready, 1'b1);
    tick();
    d_valid = 1'b0;
    repeat (L - 1) @(negedge clk);
    chk("merge_d_resp", d_resp_valid, 1'b1);
    chk("merge_p_resp", p_resp_valid, 1'b1);
    chk("merge_d_rdata", d_rdata, LINE4);
    chk("merge_p_rdata", p_rdata, LINE4);
    chk("merge_p_addr", p_resp_addr, 32'h40);

    // Write then read back.
    demand_check(32'h20, 1'b1, DEAD, 128'h0);
    demand_check(32'h20, 1'b0, '0, DEAD);

    // Reset during the second BUSY cycle of a write.
    we_before = we_pulses;
    tick();
    d_valid = 1'b1; d_addr = 32'h30; d_we = 1'b1; d_wdata = 128'h5555;
    @(negedge clk);
    chk("rstw_d_ready", d_ready, 1'b1);
    tick();
    d_valid = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    chk("rstw_d_ready0", d_ready, 1'b0);
    chk("rstw_p_ready0", p_ready, 1'b0);
    chk("rstw_mem_addr0", mem_addr, 32'h0);
    chk("rstw_mem_din0", mem_din, 128'h0);
    chk("rstw_mem_we0", mem_we, 1'b0);
    chk("rstw_resp0", {d_resp_valid, p_resp_valid}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready_first", d_ready, 1'b0);
    @(negedge clk);
    chk("rstw_ready_next", d_ready, 1'b1);
    chk("rstw_no_we", we_pulses, we_before);
    chk("rstw_line_kept", mem[3], LINE3);
    demand_check(32'h30, 1'b0, '0, LINE3);

    // Out-of-range read.
    demand_check(32'h0000_0400, 1'b0, '0, 128'h0);

    // Random traffic with occasional asynchronous resets.
    df = 1'b0; pf = 1'b0; rc = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (rc > 0) begin
        rc--;
        if (rc == 0) rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        rc = 2;
      end
      if (df) d_valid = 1'b0;
      if (pf) p_valid = 1'b0;
      if (!d_valid && $urandom_range(0, 2) == 0) begin
        d_valid = 1'b1;
        d_we    = ($urandom_range(0, 3) == 0);
        d_addr  = ($urandom_range(0, 2) == 0) ? {p_addr[31:4], 4'($urandom_range(0, 15))} : rand_addr();
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!p_valid && $urandom_range(0, 3) == 0) begin
        p_valid = 1'b1;
        p_addr  = rand_addr();
      end
      @(negedge clk);
      df = d_valid && d_ready;
      pf = p_valid && p_ready;
    end
    tick();
    rst = 1'b0; d_valid = 1'b0; p_valid = 1'b0;
    repeat (L + 4) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set the memory access cycles per request; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 d_valid / d_ready  input / output  1 / 1  demand request handshake from the cache miss path.
REQ-005 d_addr  input  32  demand byte address; d_we input 1 (1 = line write); d_wdata input 128 (write line).
REQ-006 p_valid / p_ready  input / output  1 / 1  prefetch request handshake; prefetch requests are read-only.
REQ-007 p_addr  input  32  prefetch byte address.
REQ-008 d_resp_valid  output 1; d_rdata  output 128  demand response pulse and line data.
REQ-009 p_resp_valid  output 1; p_rdata  output 128; p_resp_addr  output 32  prefetch response pulse, line data, line address.
REQ-010 mem_addr  output 32; mem_din  output 128; mem_we  output 1; mem_dout  input 128  line-memory port (combinational read, synchronous write).

Function
REQ-011 States SHALL be IDLE, BUSY, RESP; d_ready and p_ready are asserted only in IDLE, except as in REQ-017.
REQ-012 In IDLE with both valids high, the demand request SHALL win; p_ready is deasserted that cycle.
REQ-013 On accept, address SHALL be latched with bits [3:0] forced to 0 (16-byte line alignment), plus we, wdata and source tag.
REQ-014 BUSY SHALL last exactly LATENCY cycles, counter loaded with LATENCY-1 and decremented to 0; mem_addr drives the latched address throughout BUSY and is 0 otherwise.
REQ-015 mem_we SHALL be high only in the final BUSY cycle (counter 0) of a write; mem_din drives latched wdata during BUSY.
REQ-016 In the final BUSY cycle of a read, mem_dout SHALL be captured into the response register; RESP lasts one cycle, then IDLE.
REQ-017 While BUSY on a prefetch read of line A, a demand read to line A SHALL be accepted (d_ready high that cycle) and merged; RESP then pulses both d_resp_valid and p_resp_valid with the same data.
REQ-018 Demand writes, or demand reads to a different line, SHALL wait while BUSY; d_valid held high is served at the next IDLE.
REQ-019 For writes, d_resp_valid SHALL pulse in RESP as the completion acknowledgement, with d_rdata = 0.
REQ-020 Response latency SHALL be exactly LATENCY cycles after the accepting edge; the initiation interval is LATENCY+2 cycles.
REQ-021 Out-of-range addresses are passed through unchanged; the memory returns zero data for them, and the arbiter does not flag an error.
REQ-022 Response pulses SHALL be single-cycle, with no back-pressure; the consumer must accept them.

Reset
REQ-023 Asserting rst SHALL force IDLE, counter 0, and all outputs 0 (ready signals included), effective immediately and independent of clk.
REQ-024 Reset mid-BUSY SHALL abandon the request: no mem_we pulse, no response.
REQ-025 d_ready and p_ready SHALL first be able to rise in the cycle after rst deasserts.

Structure
REQ-026 The state enum, the LINE_BYTES=16 and LINE_BITS=128 constants and the line-align function SHALL reside in shared package mem_pkg.
REQ-027 One sub-module, mem_lat_counter (load, decrement, zero flag), SHALL implement the LATENCY countdown.

Verification
REQ-028 Demand read 0x0000_0010 with LATENCY=4, memory line = 0x00..0F bytes -> d_resp_valid exactly 4 cycles after accept, d_rdata = 0x0F0E..0100.
REQ-029 d_valid and p_valid both raised in the same cycle -> demand served first; prefetch accepted in the IDLE cycle after demand RESP.
REQ-030 Prefetch read 0x40, then demand read 0x4C two cycles later -> demand merged; both responses pulse together with identical data; p_resp_addr = 0x40.
REQ-031 Demand write 0x20 of 128'hDEAD.. -> one mem_we pulse in the last BUSY cycle, d_resp_valid with d_rdata = 0; a following read of 0x20 returns the written data.
REQ-032 rst asserted in the 2nd BUSY cycle of a write -> outputs 0 immediately; mem_we never pulses; memory line unchanged.
REQ-033 Read 0x0000_0400 (out of range) -> d_rdata = 0 and d_resp_valid asserted normally.
